divisor_segmentado_param: RTL and testbench



---
 rtl/divisor_segmentado_param.sv | 141 ++++++++++++++
 tb/tb_divisor_segmentado_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_segmentado_param.sv
// Purpose: pipelined restoring integer divider, signed/unsigned per operation, with tag, divide-by-zero and overflow flags.
// Latency: WIDTH/BITS_PER_STAGE + 1 cycles from the accepting edge to Out_valid; one operation per clock when not stalled.
// Backpressure: Out_valid & ~Out_ready freezes every stage and drops In_ready in the same cycle; Flush wins over the stall.
//
// Ports:
//   CLK, RSTa (sync, active high), Flush (drop everything in flight)
//   In_valid/In_ready, Signed_op, Num, Den, Tag_in   : operation input
//   Out_valid/Out_ready, Coc, Res, Tag_out           : quotient/remainder output
//   Div_zero, Ovf                                    : flags, meaningful only while Out_valid=1
module divisor_segmentado_param #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_W          = 4
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic             Flush,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic             Signed_op,
  input  logic [WIDTH-1:0] Num,
  input  logic [WIDTH-1:0] Den,
  input  logic [TAG_W-1:0] Tag_in,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Coc,
  output logic [WIDTH-1:0] Res,
  output logic [TAG_W-1:0] Tag_out,
  output logic             Div_zero,
  output logic             Ovf
);

  localparam int S = WIDTH / BITS_PER_STAGE;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if ((WIDTH < 2) || ((WIDTH % BITS_PER_STAGE) != 0)) begin : g_param_chk
    $fatal(1, "divisor_segmentado_param: WIDTH must be >= 2 and a multiple of BITS_PER_STAGE");
  end

  // Per-operation state. accu never exceeds the divisor, so WIDTH bits hold it;
  // only the shifted value used in the compare needs the extra bit.
  typedef struct packed {
    logic             vld;
    logic             sn;
    logic             sd;
    logic             dz;
    logic             ovf;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] accu;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
  } stage_t;

  // st[0] is the preprocessed operand register, st[1..S] the iteration stages.
  stage_t st [0:S];
  stage_t pre;
  logic   stall;

  logic [WIDTH-1:0] coc_nxt;
  logic [WIDTH-1:0] res_nxt;

  assign stall    = Out_valid & ~Out_ready;
  assign In_ready = ~stall;

  // BITS_PER_STAGE restoring steps on {accu, q}.
  function automatic stage_t iterate(input stage_t s);
    stage_t         r;
    logic [WIDTH:0] sh;
    r = s;
    for (int b = 0; b < BITS_PER_STAGE; b++) begin
      sh = {r.accu, r.q[WIDTH-1]};
      if (sh >= {1'b0, r.m}) begin
        r.accu = sh[WIDTH-1:0] - r.m;
        r.q    = {r.q[WIDTH-2:0], 1'b1};
      end else begin
        r.accu = sh[WIDTH-1:0];
        r.q    = {r.q[WIDTH-2:0], 1'b0};
      end
    end
    return r;
  endfunction

  // Unsigned operations get sign bits forced to 0, so the magnitude path is a no-op.
  always_comb begin
    pre      = '0;
    pre.vld  = In_valid & In_ready;
    pre.sn   = Signed_op & Num[WIDTH-1];
    pre.sd   = Signed_op & Den[WIDTH-1];
    pre.dz   = (Den == '0);
    pre.ovf  = Signed_op & (Num == MIN_NEG) & (Den == '1);
    pre.tag  = Tag_in;
    pre.accu = '0;
    pre.q    = pre.sn ? -Num : Num;
    pre.m    = pre.sd ? -Den : Den;
  end

  // With a zero divisor every step subtracts nothing: q ends all ones and accu ends
  // as |Num|, so re-applying the numerator sign restores the original Num bit pattern.
  always_comb begin
    coc_nxt = (st[S].sn ^ st[S].sd) ? -st[S].q : st[S].q;
    res_nxt = st[S].sn ? -st[S].accu : st[S].accu;
    if (st[S].dz) begin
      coc_nxt = '1;
    end else if (st[S].ovf) begin
      coc_nxt = MIN_NEG;
      res_nxt = '0;
    end
  end

  // Data registers only load behind a valid operation, so bubbles do not toggle them.
  always_ff @(posedge CLK) begin
    if (RSTa) begin
      for (int i = 0; i <= S; i++) st[i] <= '0;
      Out_valid <= 1'b0;
      Coc       <= '0;
      Res       <= '0;
      Tag_out   <= '0;
      Div_zero  <= 1'b0;
      Ovf       <= 1'b0;
    end else if (Flush) begin
      for (int i = 0; i <= S; i++) st[i].vld <= 1'b0;
      Out_valid <= 1'b0;
    end else if (!stall) begin
      if (pre.vld) st[0] <= pre;
      else         st[0].vld <= 1'b0;
      for (int i = 1; i <= S; i++) begin
        if (st[i-1].vld) st[i] <= iterate(st[i-1]);
        else             st[i].vld <= 1'b0;
      end
      Out_valid <= st[S].vld;
      if (st[S].vld) begin
        Coc      <= coc_nxt;
        Res      <= res_nxt;
        Tag_out  <= st[S].tag;
        Div_zero <= st[S].dz;
        Ovf      <= st[S].ovf;
      end
    end
  end

endmodule

// File: tb/tb_divisor_segmentado_param.sv
// Bench for divisor_segmentado_param: a 1-bit/stage and a 4-bit/stage instance share stimulus.
module tb_divisor_segmentado_param;

  logic        clk = 1'b0;
  logic        rsta, flush, in_valid, signed_op, out_ready;
  logic [31:0] num, den;
  logic [3:0]  tag_in;

  logic        b1_in_ready, b1_out_valid, b1_div_zero, b1_ovf;
  logic [31:0] b1_coc, b1_res;
  logic [3:0]  b1_tag_out;
  logic        b4_in_ready, b4_out_valid, b4_div_zero, b4_ovf;
  logic [31:0] b4_coc, b4_res;
  logic [3:0]  b4_tag_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] coc;
    logic [31:0] res;
    logic        dz;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  exp_t exq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  divisor_segmentado_param #(.WIDTH(32), .BITS_PER_STAGE(1), .TAG_W(4)) u_div1 (
    .CLK(clk), .RSTa(rsta), .Flush(flush), .In_valid(in_valid), .In_ready(b1_in_ready),
    .Signed_op(signed_op), .Num(num), .Den(den), .Tag_in(tag_in),
    .Out_valid(b1_out_valid), .Out_ready(out_ready), .Coc(b1_coc), .Res(b1_res),
    .Tag_out(b1_tag_out), .Div_zero(b1_div_zero), .Ovf(b1_ovf)
  );

  divisor_segmentado_param #(.WIDTH(32), .BITS_PER_STAGE(4), .TAG_W(4)) u_div4 (
    .CLK(clk), .RSTa(rsta), .Flush(flush), .In_valid(in_valid), .In_ready(b4_in_ready),
    .Signed_op(signed_op), .Num(num), .Den(den), .Tag_in(tag_in),
    .Out_valid(b4_out_valid), .Out_ready(out_ready), .Coc(b4_coc), .Res(b4_res),
    .Tag_out(b4_tag_out), .Div_zero(b4_div_zero), .Ovf(b4_ovf)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference built on the language's own / and % (truncating, remainder follows dividend).
  function automatic exp_t ref_div(input logic s, input logic [31:0] n, input logic [31:0] d,
                                   input logic [3:0] t);
    exp_t e;
    e.tag = t;
    e.dz  = (d == 32'd0);
    e.ovf = s && (n == 32'h8000_0000) && (d == 32'hFFFF_FFFF);
    if (e.dz) begin
      e.coc = 32'hFFFF_FFFF;
      e.res = n;
    end else if (e.ovf) begin
      e.coc = 32'h8000_0000;
      e.res = 32'd0;
    end else if (s) begin
      e.coc = $signed(n) / $signed(d);
      e.res = $signed(n) % $signed(d);
    end else begin
      e.coc = n / d;
      e.res = n % d;
    end
    return e;
  endfunction

  task automatic do_reset();
    rsta = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rsta = 1'b0;
  endtask

  task automatic drive(input logic s, input logic [31:0] n, input logic [31:0] d, input logic [3:0] t);
    in_valid = 1'b1; signed_op = s; num = n; den = d; tag_in = t;
  endtask

  // One operation through the 1-bit/stage divider, with latency and result checks.
  task automatic run1(input string name, input logic s, input logic [31:0] n, input logic [31:0] d,
                      input logic [3:0] t, input logic [31:0] ecoc, input logic [31:0] eres,
                      input logic edz, input logic eovf);
    int lat;
    drive(s, n, d, t);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!b1_out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, 33);
    chk({name, "_coc"}, b1_coc, ecoc);
    chk({name, "_res"}, b1_res, eres);
    chk({name, "_dz"},  b1_div_zero, edz);
    chk({name, "_ovf"}, b1_ovf, eovf);
    chk({name, "_tag"}, b1_tag_out, t);
    @(posedge clk); #1;
  endtask

  logic [31:0] bb_n   [3] = '{32'hFFFF_FFF9, 32'd7,          32'hFFFF_FFF9};
  logic [31:0] bb_d   [3] = '{32'd2,         32'hFFFF_FFFE,  32'hFFFF_FFFE};
  logic [31:0] bb_coc [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD,  32'd3};
  logic [31:0] bb_res [3] = '{32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF};

  logic        st_s [20];
  logic [31:0] st_n [20];
  logic [31:0] st_d [20];

  initial begin
    int lat, acc0, sent, got, first_seen, stall_left, seen;
    exp_t e;
    signed_op = 1'b0; num = '0; den = '0; tag_in = '0;

    // Reset state
    do_reset();
    chk("rst_vld1", b1_out_valid, 0);
    chk("rst_vld4", b4_out_valid, 0);
    chk("rst_coc",  b1_coc, 0);
    chk("rst_res",  b1_res, 0);
    chk("rst_tag",  b1_tag_out, 0);
    chk("rst_dz",   b1_div_zero, 0);
    chk("rst_ovf",  b1_ovf, 0);
    chk("rst_rdy1", b1_in_ready, 1);
    chk("rst_rdy4", b4_in_ready, 1);

    // Directed single operations, 1 bit per stage
    run1("s7_2",    1'b1, 32'd7,          32'd2,          4'd1, 32'd3,          32'd1,          1'b0, 1'b0);
    run1("u_big",   1'b0, 32'hFFFF_FFF9,  32'd2,          4'd2, 32'h7FFF_FFFC,  32'd1,          1'b0, 1'b0);
    run1("s_big",   1'b1, 32'hFFFF_FFF9,  32'd2,          4'd3, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0);
    run1("dz_u",    1'b0, 32'd5,          32'd0,          4'd4, 32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0);
    run1("dz_neg",  1'b1, 32'hFFFF_FFF9,  32'd0,          4'd5, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1'b0);
    run1("ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  4'd6, 32'h8000_0000,  32'd0,          1'b0, 1'b1);
    run1("u_min",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  4'd7, 32'd0,          32'h8000_0000,  1'b0, 1'b0);

    // Back-to-back signed operations, results on consecutive cycles
    do_reset();
    acc0 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bb_n[i], bb_d[i], 4'(i + 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!b1_out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bb_lat", cyc - acc0, 33);
    for (int i = 0; i < 3; i++) begin
      chk("bb_vld", b1_out_valid, 1);
      chk("bb_coc", b1_coc, bb_coc[i]);
      chk("bb_res", b1_res, bb_res[i]);
      chk("bb_tag", b1_tag_out, 4'(i + 1));
      @(posedge clk); #1;
    end
    chk("bb_end", b1_out_valid, 0);

    // Stream of 20 operations on 4 bits per stage, 5-cycle stall at the first result
    for (int i = 0; i < 20; i++) begin
      st_s[i] = 1'($urandom_range(0, 1));
      st_n[i] = $urandom;
      st_d[i] = $urandom >> $urandom_range(0, 31);
    end
    st_d[5] = 32'd0;
    st_s[9] = 1'b1; st_n[9] = 32'h8000_0000; st_d[9] = 32'hFFFF_FFFF;
    st_s[12] = 1'b1; st_n[12] = 32'hFFFF_FF9C; st_d[12] = 32'd7;

    do_reset();
    exq.delete();
    sent = 0; got = 0; first_seen = 0; stall_left = 0; acc0 = 0;
    for (int c = 0; c < 400 && got < 20; c++) begin
      if (b4_out_valid && first_seen == 0) begin
        first_seen = 1;
        chk("s_lat", cyc - acc0, 9);
        stall_left = 5;
      end
      out_ready = (stall_left == 0);
      if (sent < 20) drive(st_s[sent], st_n[sent], st_d[sent], 4'(sent));
      else           in_valid = 1'b0;
      #1;
      if (stall_left > 0) begin
        chk("hold_vld", b4_out_valid, 1);
        chk("hold_rdy", b4_in_ready, 0);
        if (exq.size() > 0) begin
          chk("hold_coc", b4_coc, exq[0].coc);
          chk("hold_res", b4_res, exq[0].res);
        end
        stall_left--;
      end
      if (b4_out_valid && out_ready) begin
        if (exq.size() == 0) begin
          chk("s_extra", 1, 0);
        end else begin
          e = exq.pop_front();
          chk("s_coc", b4_coc, e.coc);
          chk("s_res", b4_res, e.res);
          chk("s_tag", b4_tag_out, e.tag);
          chk("s_dz",  b4_div_zero, e.dz);
          chk("s_ovf", b4_ovf, e.ovf);
        end
        got++;
      end
      if (in_valid && b4_in_ready) begin
        if (sent == 0) acc0 = cyc + 1;
        exq.push_back(ref_div(st_s[sent], st_n[sent], st_d[sent], 4'(sent)));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("s_count", got, 20);
    chk("s_left", exq.size(), 0);
    seen = 0;
    repeat (15) begin
      if (b4_out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("s_dup", seen, 0);

    // Flush with three in flight plus one presented in the flush cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'(100 + i), 32'd3, 4'(i));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    drive(1'b0, 32'd50, 32'd5, 4'd8);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (40) begin
      if (b1_out_valid || b4_out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("fl_none", seen, 0);

    // Pipeline still usable after flush
    drive(1'b1, 32'hFFFF_FF9C, 32'd7, 4'd9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!b4_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("fl_lat", lat, 9);
    chk("fl_coc", b4_coc, 32'hFFFF_FFF2);
    chk("fl_res", b4_res, 32'hFFFF_FFFE);
    chk("fl_tag", b4_tag_out, 4'd9);
    @(posedge clk); #1;

    // Reset in mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(200 + i), 32'd9, 4'(i + 10));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rsta = 1'b1;
    drive(1'b0, 32'd77, 32'd7, 4'd15);
    @(posedge clk); #1;
    rsta = 1'b0; in_valid = 1'b0;
    chk("mr_vld", b4_out_valid, 0);
    chk("mr_coc", b4_coc, 0);
    chk("mr_res", b4_res, 0);
    chk("mr_tag", b4_tag_out, 0);
    chk("mr_dz",  b4_div_zero, 0);
    chk("mr_ovf", b4_ovf, 0);
    chk("mr_rdy", b4_in_ready, 1);
    seen = 0;
    repeat (40) begin
      if (b1_out_valid || b4_out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("mr_none", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "simulation time limit reached");
  end

endmodule
